// File: rtl/neuro_link_defs.sv
// Shared definitions for the neuron configuration link (transmitter and receive controller).
package neuro_link_defs;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned VALUE_W = 32;
    localparam int unsigned IDX_W   = 4;

    localparam logic [BYTE_W-1:0] OP_CTRL_SET        = 8'h01;
    localparam logic [BYTE_W-1:0] OP_WEIGHT_SET      = 8'h02;
    localparam logic [BYTE_W-1:0] OP_ADDR_WEIGHT_SET = 8'h03;
    localparam logic [BYTE_W-1:0] OP_END             = 8'hFF;
    localparam logic [BYTE_W-1:0] END_PACKET         = 8'hFF;

    localparam logic [IDX_W-1:0] LEN_CTRL_SET        = 4'd3;
    localparam logic [IDX_W-1:0] LEN_WEIGHT_SET      = 4'd7;
    localparam logic [IDX_W-1:0] LEN_ADDR_WEIGHT_SET = 4'd9;
    localparam logic [IDX_W-1:0] LEN_END             = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STRB_HI,
        ST_STRB_LO,
        ST_DONE
    } link_state_e;

    typedef struct packed {
        logic [BYTE_W-1:0]  opcode;
        logic [2:0]         decay_mode;
        logic [2:0]         init_adder;
        logic [1:0]         adder_model;
        logic               init_acc;
        logic [ADDR_W-1:0]  address;
        logic [VALUE_W-1:0] value;
        logic               last;
    } neuro_cmd_t;

    // Opcodes the transmitter knows how to serialize.
    function automatic logic opcode_known(input logic [BYTE_W-1:0] op);
        return (op == OP_CTRL_SET) || (op == OP_WEIGHT_SET) ||
               (op == OP_ADDR_WEIGHT_SET) || (op == OP_END);
    endfunction

    // Packet length in bytes for each opcode, excluding any appended END.
    function automatic logic [IDX_W-1:0] opcode_len(input logic [BYTE_W-1:0] op);
        logic [IDX_W-1:0] len;
        case (op)
            OP_CTRL_SET:        len = LEN_CTRL_SET;
            OP_WEIGHT_SET:      len = LEN_WEIGHT_SET;
            OP_ADDR_WEIGHT_SET: len = LEN_ADDR_WEIGHT_SET;
            default:            len = LEN_END;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/neuro_link_strobe.sv
// Byte-slot timer: counts SETUP (cnt 0), strobe-high (1..HIGH) and strobe-low cycles of one slot.
module neuro_link_strobe #(
    parameter int unsigned STROBE_HIGH = 2,
    parameter int unsigned STROBE_LOW  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic hi_end_c,
    output logic slot_end_c
);

    localparam int unsigned CNT_W     = 5;
    localparam int unsigned HI_LAST   = STROBE_HIGH;
    localparam int unsigned SLOT_LAST = STROBE_HIGH + STROBE_LOW;

    logic [CNT_W-1:0] cnt_q;

    // Slot cycle counter; restarts at each slot boundary and idles at zero.
    always_ff @(posedge clk) begin
        if (rst || !run || slot_end_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hi_end_c   = (cnt_q == CNT_W'(HI_LAST));
    assign slot_end_c = (cnt_q == CNT_W'(SLOT_LAST));

endmodule

// File: rtl/neuron_config_tx.sv
// Byte-serial neuron configuration transmitter driving the data/load_data link.
// Optional build macro NEURO_TX_AUTO_END_EN: append an END_PACKET slot when cmd_last is captured.
module neuron_config_tx
    import neuro_link_defs::*;
#(
    parameter int unsigned STROBE_HIGH = 2,
    parameter int unsigned STROBE_LOW  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [BYTE_W-1:0]  cmd_opcode,
    input  logic [2:0]         cmd_decay_mode,
    input  logic [2:0]         cmd_init_adder,
    input  logic [1:0]         cmd_adder_model,
    input  logic               cmd_init_acc,
    input  logic [ADDR_W-1:0]  cmd_address,
    input  logic [VALUE_W-1:0] cmd_value,
    input  logic               cmd_last,
    output logic [BYTE_W-1:0]  data,
    output logic               load_data,
    output logic               busy,
    output logic               done,
    output logic               cmd_err
);

    link_state_e       state_q, state_d;
    neuro_cmd_t        cmd_q, cmd_d, cmd_in;
    logic [IDX_W-1:0]  idx_q, idx_d, last_idx_c;
    logic [BYTE_W-1:0] data_d;
    logic              ready_d, load_d, busy_d, done_d, err_d, in_slot_d;
    logic              hi_end_c, slot_end_c, run_c;

`ifndef NEURO_TX_AUTO_END_EN
    logic unused_cmd_last;
    assign unused_cmd_last = cmd_last;
`endif

    // Byte sent in slot i of the packet; slots past the opcode's length carry END_PACKET.
    function automatic logic [BYTE_W-1:0] link_byte(input neuro_cmd_t c, input logic [IDX_W-1:0] i);
        logic [BYTE_W-1:0] c0, c1, a0, a1, b;
        c0 = {c.adder_model, c.init_adder, c.decay_mode};
        c1 = {7'b0, c.init_acc};
        a0 = c.address[7:0];
        a1 = {6'b0, c.address[9:8]};
        b  = END_PACKET;
        case (c.opcode)
            OP_CTRL_SET: begin
                case (i)
                    4'd0:    b = c.opcode;
                    4'd1:    b = c0;
                    4'd2:    b = c1;
                    default: b = END_PACKET;
                endcase
            end
            OP_WEIGHT_SET: begin
                case (i)
                    4'd0:    b = c.opcode;
                    4'd1:    b = c0;
                    4'd2:    b = c1;
                    4'd3:    b = c.value[7:0];
                    4'd4:    b = c.value[15:8];
                    4'd5:    b = c.value[23:16];
                    4'd6:    b = c.value[31:24];
                    default: b = END_PACKET;
                endcase
            end
            OP_ADDR_WEIGHT_SET: begin
                case (i)
                    4'd0:    b = c.opcode;
                    4'd1:    b = c0;
                    4'd2:    b = c1;
                    4'd3:    b = a0;
                    4'd4:    b = a1;
                    4'd5:    b = c.value[7:0];
                    4'd6:    b = c.value[15:8];
                    4'd7:    b = c.value[23:16];
                    4'd8:    b = c.value[31:24];
                    default: b = END_PACKET;
                endcase
            end
            default: b = END_PACKET;
        endcase
        return b;
    endfunction

    // Incoming command payload; cmd_last never extends an OP_END packet.
    always_comb begin
        cmd_in.opcode      = cmd_opcode;
        cmd_in.decay_mode  = cmd_decay_mode;
        cmd_in.init_adder  = cmd_init_adder;
        cmd_in.adder_model = cmd_adder_model;
        cmd_in.init_acc    = cmd_init_acc;
        cmd_in.address     = cmd_address;
        cmd_in.value       = cmd_value;
`ifdef NEURO_TX_AUTO_END_EN
        cmd_in.last        = cmd_last && (cmd_opcode != OP_END);
`else
        cmd_in.last        = 1'b0;
`endif
    end

    assign last_idx_c = opcode_len(cmd_q.opcode) + IDX_W'(cmd_q.last) - IDX_W'(1);
    assign run_c      = (state_q == ST_SETUP) || (state_q == ST_STRB_HI) || (state_q == ST_STRB_LO);

    neuro_link_strobe #(
        .STROBE_HIGH (STROBE_HIGH),
        .STROBE_LOW  (STROBE_LOW)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .run        (run_c),
        .hi_end_c   (hi_end_c),
        .slot_end_c (slot_end_c)
    );

    // Next-state logic and next values of the registered link outputs.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                idx_d = '0;
                if (cmd_valid) begin
                    if (opcode_known(cmd_opcode)) begin
                        cmd_d   = cmd_in;
                        state_d = ST_SETUP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_SETUP:   state_d = ST_STRB_HI;
            ST_STRB_HI: if (hi_end_c) state_d = ST_STRB_LO;
            ST_STRB_LO: begin
                if (slot_end_c) begin
                    if (idx_q == last_idx_c) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        in_slot_d = (state_d == ST_SETUP) || (state_d == ST_STRB_HI) || (state_d == ST_STRB_LO);
        busy_d    = in_slot_d;
        load_d    = (state_d == ST_STRB_HI);
        done_d    = (state_d == ST_DONE);
        ready_d   = (state_d == ST_IDLE);
        data_d    = in_slot_d ? link_byte(cmd_d, idx_d) : '0;
    end

    // State, command and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            idx_q     <= '0;
            cmd_ready <= 1'b1;
            data      <= '0;
            load_data <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            idx_q     <= idx_d;
            cmd_ready <= ready_d;
            data      <= data_d;
            load_data <= load_d;
            busy      <= busy_d;
            done      <= done_d;
            cmd_err   <= err_d;
        end
    end

endmodule
